// File: rtl/pc_call_stack_if.sv
// pc_call_stack_if: decoder strobes into, and fetch address/stack status out of, the PC unit
interface pc_call_stack_if #(
  parameter int CNTR_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 4
);
  logic                   en;
  logic                   jmp;
  logic                   cal_f;
  logic                   ret_f;
  logic                   rst_f;
  logic [CNTR_WIDTH-1:0]  jmp_addr;
  logic [CNTR_WIDTH-1:0]  pc;
  logic [DEPTH_WIDTH-1:0] stk_depth;
  logic                   stk_ovf;
  logic                   stk_unf;
  modport master (
    output en, jmp, cal_f, ret_f, rst_f, jmp_addr,
    input  pc, stk_depth, stk_ovf, stk_unf
  );
  modport slave (
    input  en, jmp, cal_f, ret_f, rst_f, jmp_addr,
    output pc, stk_depth, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with a bounded return-address stack and sticky ovf/unf flags
module pc_call_stack #(
  parameter int CNTR_WIDTH  = 8,
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  pc_call_stack_if.slave   bus
);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [CNTR_WIDTH-1:0]  pc_q, pc_d, pc_inc;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d, push, empty, full;
  logic [AW-1:0]          push_idx, top_idx;
  logic [CNTR_WIDTH-1:0]  stack_q [STACK_DEPTH];
  assign pc_inc   = pc_q + 1'b1;
  assign empty    = depth_q == '0;
  assign full     = depth_q == DEPTH_WIDTH'(STACK_DEPTH);
  assign push_idx = AW'(depth_q);
  assign top_idx  = AW'(depth_q - 1'b1);
  // One action per enabled cycle: soft reset, then RET, then CAL, then JMP, else step
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (bus.en) begin
      if (!bus.rst_f) begin
        pc_d    = '0;
        depth_d = '0;
      end else if (bus.jmp && bus.ret_f) begin
        if (empty) begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          pc_d    = stack_q[top_idx];
          depth_d = depth_q - 1'b1;
        end
      end else if (bus.jmp && bus.cal_f) begin
        if (full) begin
          ovf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          push    = 1'b1;
          depth_d = depth_q + 1'b1;
          pc_d    = bus.jmp_addr;
        end
      end else begin
        pc_d = bus.jmp ? bus.jmp_addr : pc_inc;
      end
    end
  end
  // Control state; only the hard reset clears the sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // Return-address storage; entries above depth are never read, so no reset
  always_ff @(posedge clk) begin
    if (push && !rst) stack_q[push_idx] <= pc_inc;
  end
  assign bus.pc        = pc_q;
  assign bus.stk_depth = depth_q;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;
endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: directed and random checks of pc_call_stack against a queue-based model
module tb_pc_call_stack;
  localparam int SD = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   mpc = 0;
  int   stk[$];
  bit   movf = 0, munf = 0;
  pc_call_stack_if #(.CNTR_WIDTH(8), .DEPTH_WIDTH(4)) bus ();
  pc_call_stack #(.CNTR_WIDTH(8), .STACK_DEPTH(SD), .DEPTH_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_model(string tag);
    check({tag, ".pc"}, int'(bus.pc), mpc);
    check({tag, ".depth"}, int'(bus.stk_depth), stk.size());
    check({tag, ".ovf"}, int'(bus.stk_ovf), int'(movf));
    check({tag, ".unf"}, int'(bus.stk_unf), int'(munf));
  endtask
  task automatic hard_reset();
    rst = 1'b1;
    bus.jmp = 1'b1;
    bus.cal_f = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mpc = 0;
    stk.delete();
    movf = 0;
    munf = 0;
    check_model("reset");
  endtask
  task automatic step(string tag, bit e, bit j, bit c, bit r, bit rf, int a);
    bus.en = e;
    bus.jmp = j;
    bus.cal_f = c;
    bus.ret_f = r;
    bus.rst_f = rf;
    bus.jmp_addr = 8'(a);
    @(posedge clk);
    #1;
    if (e) begin
      if (!rf) begin
        mpc = 0;
        stk.delete();
      end else if (j && r) begin
        if (stk.size() > 0) mpc = stk.pop_back();
        else begin
          munf = 1;
          mpc = (mpc + 1) % 256;
        end
      end else if (j && c) begin
        if (stk.size() < SD) begin
          stk.push_back((mpc + 1) % 256);
          mpc = a;
        end else begin
          movf = 1;
          mpc = (mpc + 1) % 256;
        end
      end else if (j) mpc = a;
      else mpc = (mpc + 1) % 256;
    end
    check_model(tag);
  endtask
  initial begin
    bus.en = 1'b1;
    bus.jmp = 1'b0;
    bus.cal_f = 1'b0;
    bus.ret_f = 1'b0;
    bus.rst_f = 1'b1;
    bus.jmp_addr = '0;
    hard_reset();
    check("reset.pc0", int'(bus.pc), 0);
    for (int i = 1; i <= 5; i++) begin
      step("run", 1, 0, 0, 0, 1, 0);
      check("run.pc", int'(bus.pc), i);
    end
    hard_reset();
    for (int i = 0; i < 3; i++) step("pre", 1, 0, 0, 0, 1, 0);
    step("jmp", 1, 1, 0, 0, 1, 'hFE);
    check("jmp.pc", int'(bus.pc), 'hFE);
    step("wrap1", 1, 0, 0, 0, 1, 0);
    check("wrap1.pc", int'(bus.pc), 'hFF);
    step("wrap2", 1, 0, 0, 0, 1, 0);
    check("wrap2.pc", int'(bus.pc), 0);
    step("to10", 1, 1, 0, 0, 1, 'h10);
    step("cal1", 1, 1, 1, 0, 1, 'h40);
    check("cal1.pc", int'(bus.pc), 'h40);
    step("nop", 1, 0, 0, 0, 1, 0);
    step("cal2", 1, 1, 1, 0, 1, 'h80);
    check("cal2.depth", int'(bus.stk_depth), 2);
    step("ret1", 1, 1, 0, 1, 1, 0);
    check("ret1.pc", int'(bus.pc), 'h42);
    step("ret2", 1, 1, 0, 1, 1, 0);
    check("ret2.pc", int'(bus.pc), 'h11);
    step("ocal1", 1, 1, 1, 0, 1, 'h20);
    step("ocal2", 1, 1, 1, 0, 1, 'h30);
    step("ocal3", 1, 1, 1, 0, 1, 'h50);
    check("ovf.pc", int'(bus.pc), 'h31);
    check("ovf.flag", int'(bus.stk_ovf), 1);
    step("oret1", 1, 1, 0, 1, 1, 0);
    check("oret1.pc", int'(bus.pc), 'h21);
    step("oret2", 1, 1, 0, 1, 1, 0);
    check("oret2.ovf", int'(bus.stk_ovf), 1);
    hard_reset();
    step("to7", 1, 1, 0, 0, 1, 7);
    step("uret", 1, 1, 0, 1, 1, 0);
    check("unf.pc", int'(bus.pc), 8);
    check("unf.flag", int'(bus.stk_unf), 1);
    step("ucal", 1, 1, 1, 0, 1, 'h60);
    step("softrst", 1, 0, 0, 0, 0, 0);
    check("softrst.pc", int'(bus.pc), 0);
    check("softrst.unf", int'(bus.stk_unf), 1);
    hard_reset();
    check("hrst.unf", int'(bus.stk_unf), 0);
    step("pre2", 1, 1, 0, 0, 1, 'h12);
    step("hold", 0, 1, 0, 0, 1, 'h33);
    check("hold.pc", int'(bus.pc), 'h12);
    step("pcal", 1, 1, 1, 0, 1, 'h70);
    step("both", 1, 1, 1, 1, 1, 'h55);
    check("both.pc", int'(bus.pc), 'h13);
    check("both.depth", int'(bus.stk_depth), 0);
    step("srj", 1, 1, 0, 0, 0, 'h44);
    check("srj.pc", int'(bus.pc), 0);
    step("midcal", 1, 1, 1, 0, 1, 'h90);
    hard_reset();
    step("midret", 1, 1, 0, 1, 1, 0);
    check("midret.unf", int'(bus.stk_unf), 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) hard_reset();
      else step("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) != 0, int'($urandom_range(0, 255)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
